// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
// Contents: FSM state encoding, base opcode constants, immediate-format
// select codes, write-back select codes, and the decoded-control record
// passed from ctrl_decode to multi_cycle_ctrl.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERR
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_SHAMT = 3'd2,
    IMM_S     = 3'd3,
    IMM_B     = 3'd4,
    IMM_J     = 3'd5,
    IMM_U     = 3'd6
  } imm_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef struct packed {
    logic     legal;
    logic     is_load;
    logic     is_store;
    logic     is_branch;
    logic     is_jump;
    imm_sel_t imm_sel;
    logic     alu_a_sel;
    logic     alu_b_sel;
    wb_sel_t  wb_sel;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// ctrl_decode: combinational opcode-to-control decode.
// Ports:
//   opcode [6:0] in  - instr[6:0]
//   funct3 [2:0] in  - instr[14:12], distinguishes OP-IMM shifts
//   ctrl         out - decoded control record (ctrl_t)
// Operand selects: alu_a_sel=1 (PC) for PC-relative ops (BRANCH target,
// JAL, AUIPC); alu_b_sel=1 (immediate) for every format carrying one.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = '0;
    ctrl.legal = 1'b1;
    case (opcode)
      OPC_OP_IMM: begin
        ctrl.imm_sel   = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
        ctrl.alu_b_sel = 1'b1;
      end
      OPC_OP: ;
      OPC_LOAD: begin
        ctrl.is_load   = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.wb_sel    = WB_MEM;
      end
      OPC_STORE: begin
        ctrl.is_store  = 1'b1;
        ctrl.imm_sel   = IMM_S;
        ctrl.alu_b_sel = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.is_branch = 1'b1;
        ctrl.imm_sel   = IMM_B;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
      end
      OPC_JAL: begin
        ctrl.is_jump   = 1'b1;
        ctrl.imm_sel   = IMM_J;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_JALR: begin
        ctrl.is_jump   = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      OPC_LUI: begin
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_b_sel = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.imm_sel   = IMM_U;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
      end
      default: ctrl.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle RV32I control FSM with memory timeout.
// Ports:
//   clk, rst (sync, active-high)
//   instr[31:0], br_taken, mem_ready                      - inputs
//   mem_req, mem_we, pc_we, ir_we, reg_we                 - strobes
//   imm_sel[2:0], alu_a_sel, alu_b_sel, wb_sel[1:0], pc_sel - datapath selects
//   err                                                   - sticky error flag
// Parameter TIMEOUT (1..255): request cycles without mem_ready before ERR.
// Build option MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN: unrecognised opcodes trap
// to ERR; otherwise they execute as a NOP (no reg_we, PC+4).
// Strobes are decoded from the current state plus inputs, so ir_we, the
// branch pc_we/pc_sel and the store pc_we land in the same cycle as the
// mem_ready/br_taken that qualifies them. Only state, counter and err are flops.
module multi_cycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel,
  output logic        pc_sel,
  output logic        err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  ctrl_t      ctrl;
  logic       timeout_hit;
  logic       rd_nz;
  logic       unused_instr;

  ctrl_decode u_decode (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .ctrl   (ctrl)
  );

  assign rd_nz        = (instr[11:7] != '0);
  assign unused_instr = ^instr[31:15];
  // mem_ready in the final counted cycle wins over the timeout.
  assign timeout_hit  = (cnt_q == CNT_LAST) && !mem_ready;
  assign err          = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    err_d     = err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    imm_sel   = '0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    wb_sel    = '0;
    pc_sel    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DECODE: begin
        imm_sel = ctrl.imm_sel;
        state_d = ST_EXEC;
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
        if (!ctrl.legal) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
`endif
      end
      ST_EXEC: begin
        imm_sel   = ctrl.imm_sel;
        alu_a_sel = ctrl.alu_a_sel;
        alu_b_sel = ctrl.alu_b_sel;
        if (ctrl.is_load || ctrl.is_store) begin
          state_d = ST_MEM;
        end else if (ctrl.is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = ctrl.is_store;
        if (mem_ready) begin
          if (ctrl.is_store) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WB: begin
        reg_we  = rd_nz && ctrl.legal;
        pc_we   = 1'b1;
        wb_sel  = ctrl.wb_sel;
        pc_sel  = ctrl.is_jump;
        state_d = ST_FETCH;
      end
      ST_ERR: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting on mem_ready before a bus error (1..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction from IR; valid from DECODE onward.
- br_taken  in  1  branch-compare result from ALU, valid in EXEC.
- mem_ready  in  1  memory completion strobe.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  store qualifier for mem_req.
- pc_we  out  1  PC load strobe.
- ir_we  out  1  IR load strobe.
- reg_we  out  1  register-file write strobe.
- imm_sel  out  3  immediate-format select to the immediate generator.
- alu_a_sel  out  1  0=rs1, 1=PC.
- alu_b_sel  out  1  0=rs2, 1=immediate.
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4.
- pc_sel  out  1  0=PC+4, 1=ALU result.
- err  out  1  sticky error flag.

Function
REQ-003 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
REQ-004 SHALL leave IDLE for FETCH one cycle after rst deasserts.
REQ-005 FETCH: SHALL assert mem_req with mem_we=0 until mem_ready; on mem_ready, SHALL pulse ir_we for that cycle and go to DECODE.
REQ-006 DECODE: SHALL drive imm_sel from opcode: OP-IMM=0, OP-IMM shifts (funct3 001/101)=2, STORE=3, BRANCH=4, JAL=5, LUI/AUIPC=6, LOAD/JALR=0; then go to EXEC.
REQ-007 EXEC: SHALL hold imm_sel and set alu_a_sel/alu_b_sel per opcode; LOAD/STORE go to MEM; BRANCH pulses pc_we with pc_sel=br_taken and goes to FETCH; all other opcodes go to WB.
REQ-008 MEM: SHALL assert mem_req (mem_we=1 for STORE) until mem_ready; STORE then pulses pc_we (pc_sel=0) and goes to FETCH; LOAD goes to WB.
REQ-009 WB: SHALL pulse reg_we and pc_we in the same cycle, with wb_sel=1 for LOAD, 2 for JAL/JALR, 0 otherwise; pc_sel=1 for JAL/JALR, 0 otherwise; then go to FETCH.
REQ-010 SHALL NOT assert reg_we when instr[11:7]==0.
REQ-011 SHALL count consecutive mem_req cycles without mem_ready in an 8-bit counter cleared on entering FETCH or MEM; when the count reaches TIMEOUT, SHALL go to ERR and set err.
REQ-012 mem_ready arriving in the same cycle the count reaches TIMEOUT SHALL count as completion, not error.
REQ-013 ERR SHALL be terminal until rst; all strobes stay 0 there.
REQ-014 pc_we, ir_we, reg_we SHALL be single-cycle pulses, at most one per state visit.
REQ-015 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-016 With rst high at a clock edge: state=IDLE, counter=0, err=0, all strobes and selects 0, including mid-access (mem_req drops the next cycle).

Configuration
REQ-017 Macro MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN: when defined, an unrecognised opcode in DECODE SHALL go to ERR and set err; when undefined, it SHALL go to WB, suppress reg_we, and advance the PC by 4 (NOP).

Structure
REQ-018 State encoding, opcode constants, imm_sel codes and wb_sel codes SHALL live in shared package riscv_ctrl_pkg.
REQ-019 Opcode-to-control decode SHALL be a combinational sub-module ctrl_decode; the FSM and timeout counter stay in the top module.

Verification
REQ-020 ADDI x1,x0,5 (0x00500093), mem_ready 1 cycle after req -> FETCH,DECODE,EXEC,WB; imm_sel=0; reg_we pulse in WB.
REQ-021 SW (0x0020A023), mem_ready delayed 3 cycles in MEM -> mem_we=1 held 4 cycles; no reg_we; pc_we pulse with pc_sel=0.
REQ-022 BEQ with br_taken=1 -> imm_sel=4 in DECODE; pc_we with pc_sel=1 in EXEC; no WB state.
REQ-023 TIMEOUT=4, mem_ready held 0 in FETCH -> ERR after 4 request cycles, err=1; mem_ready on the 4th cycle -> DECODE, err=0.
REQ-024 Opcode 0x7F with and without MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN -> ERR/err=1 vs NOP with PC+4 and no reg_we.
REQ-025 rst asserted during MEM of a LOAD -> IDLE next cycle, outputs 0; FETCH the cycle after rst drops.
